inst_router: RTL

Dispatch-side transmitter for the per-FU issue queues. Accepts one renamed instruction per cycle from rename and holds it in a one-entry output slot. Presents the slot to the selected FU queue with a valid/ready handshake, and keeps a PRN ready scoreboard so that each operand leaves with a correct `prn_input_ready` bit. Snoops all FU result broadcasts so that scoreboard bits and held slot bits never go stale.

---
 rtl/inst_router.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/inst_router.sv
// Dispatch-side transmitter: one-entry output slot toward the FU issue queues,
// with a PRN ready scoreboard and broadcast snooping for operand readiness.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no instruction held; in_ready follows reset only
// ST_FULL  | slot holds an instruction presented on inst_valid[slot_sel]
module inst_router #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,

    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [INST_ID_BITS-1:0]                           in_inst_id,
    input  logic [31:0]                                       in_raw_instr,
    input  logic [63:0]                                       in_instr_pc,
    input  logic [((FU_COUNT > 1) ? $clog2(FU_COUNT) : 1)-1:0] in_fu_sel,
    input  logic [MAX_OPERANDS-1:0]                           in_prn_input_valid,
    input  logic [PRN_BITS-1:0]                               in_prn_input [MAX_OPERANDS],
    input  logic [MAX_OPERANDS-1:0]                           in_prn_output_valid,
    input  logic [PRN_BITS-1:0]                               in_prn_output [MAX_OPERANDS],

    output logic [FU_COUNT-1:0]                               inst_valid,
    input  logic [FU_COUNT-1:0]                               queue_ready,
    output logic [INST_ID_BITS-1:0]                           inst_id,
    output logic [31:0]                                       raw_instr,
    output logic [63:0]                                       instr_pc,
    output logic [MAX_OPERANDS-1:0]                           prn_input_valid,
    output logic [PRN_BITS-1:0]                               prn_input [MAX_OPERANDS],
    output logic [MAX_OPERANDS-1:0]                           prn_output_valid,
    output logic [PRN_BITS-1:0]                               prn_output [MAX_OPERANDS],
    output logic [MAX_OPERANDS-1:0]                           prn_input_ready,

    input  logic [MAX_OPERANDS-1:0]                           set_prn_ready [FU_COUNT],
    input  logic [PRN_BITS-1:0]                               set_prn [FU_COUNT][MAX_OPERANDS]
);

    localparam int SEL_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
    localparam int SB_SIZE  = 1 << PRN_BITS;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]              state;
    logic [SEL_BITS-1:0]     slot_sel;
    logic                    sel_ready;
    logic                    accept;
    logic [SB_SIZE-1:0]      scoreboard;
    logic [SB_SIZE-1:0]      scoreboard_next;
    logic [MAX_OPERANDS-1:0] accept_rdy;
    logic [MAX_OPERANDS-1:0] slot_hit;

    // An out-of-range selector matches no queue, so it never transfers.
    always_comb begin
        sel_ready  = 1'b0;
        inst_valid = '0;
        for (int f = 0; f < FU_COUNT; f++) begin
            if (int'(slot_sel) == f) begin
                sel_ready     = queue_ready[f];
                inst_valid[f] = (state == ST_FULL);
            end
        end
    end

    assign in_ready = !rst && ((state == ST_EMPTY) || sel_ready);
    assign accept   = in_valid && in_ready;

    // Readiness for incoming operands (pre-update table plus same-cycle bypass)
    // and broadcast hits against the operands already held in the slot.
    always_comb begin
        accept_rdy = '0;
        slot_hit   = '0;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            if (!in_prn_input_valid[k] || scoreboard[in_prn_input[k]]) begin
                accept_rdy[k] = 1'b1;
            end
            for (int f = 0; f < FU_COUNT; f++) begin
                for (int j = 0; j < MAX_OPERANDS; j++) begin
                    if (set_prn_ready[f][j]) begin
                        if (set_prn[f][j] == in_prn_input[k]) begin
                            accept_rdy[k] = 1'b1;
                        end
                        if (set_prn[f][j] == prn_input[k]) begin
                            slot_hit[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Clears are applied after sets so a colliding clear wins.
    always_comb begin
        scoreboard_next = scoreboard;
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                if (set_prn_ready[f][j]) begin
                    scoreboard_next[set_prn[f][j]] = 1'b1;
                end
            end
        end
        if (accept) begin
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                if (in_prn_output_valid[k]) begin
                    scoreboard_next[in_prn_output[k]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scoreboard <= '1;
        end else begin
            scoreboard <= scoreboard_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_EMPTY;
            slot_sel         <= '0;
            inst_id          <= '0;
            raw_instr        <= '0;
            instr_pc         <= '0;
            prn_input_valid  <= '0;
            prn_output_valid <= '0;
            prn_input_ready  <= '0;
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                prn_input[k]  <= '0;
                prn_output[k] <= '0;
            end
        end else if (accept) begin
            state            <= ST_FULL;
            slot_sel         <= in_fu_sel;
            inst_id          <= in_inst_id;
            raw_instr        <= in_raw_instr;
            instr_pc         <= in_instr_pc;
            prn_input_valid  <= in_prn_input_valid;
            prn_output_valid <= in_prn_output_valid;
            prn_input_ready  <= accept_rdy;
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                prn_input[k]  <= in_prn_input[k];
                prn_output[k] <= in_prn_output[k];
            end
        end else if (state == ST_FULL) begin
            if (sel_ready) begin
                state <= ST_EMPTY;
            end
            prn_input_ready <= prn_input_ready | slot_hit;
        end
    end

endmodule
